// File: rtl/ff_mac_accumulator.sv
// Multi-cycle feedforward neuron: accumulates lanes a*w products per beat over fan-in fi,
// then saturates and applies a selectable piecewise-linear activation plus its derivative.
module ff_mac_accumulator #(
  parameter int width      = 16,
  parameter int int_bits   = 5,
  parameter int frac_bits  = 10,
  parameter int lanes      = 4,
  parameter int fi         = 16,
  parameter int leak_shift = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [width*lanes-1:0]   a_package,
  input  logic [width*lanes-1:0]   w_package,
  input  logic [width-1:0]         b,
  input  logic [1:0]               act_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [width-1:0]         s_out,
  output logic [width-1:0]         act_out,
  output logic [width-1:0]         sp_out,
  output logic                     sat_out
);

  localparam int NB   = fi / lanes;
  localparam int CNTW = (NB > 1) ? $clog2(NB) : 1;
  localparam int PW   = 2*width - frac_bits;
  localparam int ACCW = 2*width - frac_bits + $clog2(fi) + 1;

  localparam logic [CNTW-1:0]        LAST_CNT = CNTW'(NB - 1);
  localparam logic [width-1:0]       ONE      = width'(2**frac_bits);
  localparam logic [width-1:0]       ONE_LEAK = ONE >> leak_shift;
  localparam logic signed [ACCW-1:0] S_MAX    = ACCW'(2**(width-1) - 1);
  localparam logic signed [ACCW-1:0] S_MIN    = ACCW'(-(2**(width-1)));

  if (1 + int_bits + frac_bits != width) begin : g_bad_format
    $error("width must equal 1 + int_bits + frac_bits");
  end
  if ((fi % lanes) != 0 || (lanes & (lanes - 1)) != 0) begin : g_bad_lanes
    $error("lanes must be a power of 2 dividing fi");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  // Returns {clipped, saturated word}.
  function automatic logic [width:0] saturate(input logic signed [ACCW-1:0] f);
    if (f > S_MAX) begin
      saturate = {1'b1, 1'b0, {(width-1){1'b1}}};
    end else if (f < S_MIN) begin
      saturate = {1'b1, 1'b1, {(width-1){1'b0}}};
    end else begin
      saturate = {1'b0, f[width-1:0]};
    end
  endfunction

  // Returns {act, sp}; modes 0 and 3 are both identity.
  function automatic logic [2*width-1:0] activate(input logic signed [width-1:0] s,
                                                  input logic [1:0] mode);
    case (mode)
      2'd1: begin
        if (!s[width-1] && (s != {width{1'b0}})) begin
          activate = {s, ONE};
        end else begin
          activate = {{width{1'b0}}, {width{1'b0}}};
        end
      end
      2'd2: begin
        if (!s[width-1]) begin
          activate = {s, ONE};
        end else begin
          activate = {s >>> leak_shift, ONE_LEAK};
        end
      end
      2'd0:    activate = {s, ONE};
      2'd3:    activate = {s, ONE};
      default: activate = {s, ONE};
    endcase
  endfunction

  state_t                  state_r, state_next_s;
  logic [CNTW-1:0]         cnt_r;
  logic signed [ACCW-1:0]  acc_r;
  logic [1:0]              mode_r;

  logic signed [2*width-1:0] prod_s;
  logic signed [ACCW-1:0]    lane_sum_s;
  logic signed [ACCW-1:0]    base_s;
  logic signed [ACCW-1:0]    final_s;
  logic [1:0]                mode_s;
  logic                      fire_s, first_s, last_s;
  logic [width:0]            sat_s;
  logic [2*width-1:0]        act_s;

  assign in_ready = !reset && ((state_r != OUT) || out_ready);

  // Sum of per-lane products, each truncated toward minus infinity by dropping frac_bits.
  always_comb begin
    prod_s     = {(2*width){1'b0}};
    lane_sum_s = {ACCW{1'b0}};
    for (int k = 0; k < lanes; k++) begin
      prod_s     = $signed(a_package[width*k +: width]) * $signed(w_package[width*k +: width]);
      lane_sum_s = lane_sum_s + {{(ACCW-PW){prod_s[2*width-1]}}, prod_s[2*width-1:frac_bits]};
    end
  end

  // Beat classification and final-sum datapath; a first beat starts from the bias, not acc.
  always_comb begin
    fire_s  = in_valid && in_ready;
    first_s = fire_s && (state_r != ACCUM);
    last_s  = fire_s && ((NB == 1) || ((state_r == ACCUM) && (cnt_r == LAST_CNT)));
    if (first_s) begin
      base_s = {{(ACCW-width){b[width-1]}}, b};
      mode_s = act_mode;
    end else begin
      base_s = acc_r;
      mode_s = mode_r;
    end
    final_s = base_s + lane_sum_s;
    sat_s   = saturate(final_s);
    act_s   = activate(sat_s[width-1:0], mode_s);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; OUT may hand straight over to a new neuron when consumed.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE, ACCUM: begin
        if (last_s) begin
          state_next_s = OUT;
        end else if (fire_s) begin
          state_next_s = ACCUM;
        end else begin
          state_next_s = state_r;
        end
      end
      OUT: begin
        if (last_s) begin
          state_next_s = OUT;
        end else if (fire_s) begin
          state_next_s = ACCUM;
        end else if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = OUT;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Accumulator, beat counter and registered result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r     <= {CNTW{1'b0}};
      acc_r     <= {ACCW{1'b0}};
      mode_r    <= 2'd0;
      out_valid <= 1'b0;
      s_out     <= {width{1'b0}};
      act_out   <= {width{1'b0}};
      sp_out    <= {width{1'b0}};
      sat_out   <= 1'b0;
    end else begin
      if (first_s) begin
        mode_r <= act_mode;
      end
      if (fire_s) begin
        acc_r <= final_s;
        cnt_r <= last_s ? {CNTW{1'b0}} : cnt_r + CNTW'(1);
      end
      if (last_s) begin
        out_valid <= 1'b1;
        s_out     <= sat_s[width-1:0];
        sat_out   <= sat_s[width];
        act_out   <= act_s[2*width-1:width];
        sp_out    <= act_s[width-1:0];
      end else if ((state_r == OUT) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ff_mac_accumulator.sv
// Directed bench for ff_mac_accumulator with fi = 8, lanes = 4 (two beats per neuron).
module tb_ff_mac_accumulator;
  localparam int W = 16;
  localparam int L = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W*L-1:0] a_package = '0;
  logic [W*L-1:0] w_package = '0;
  logic [W-1:0]   b = '0;
  logic [1:0]     act_mode = 2'd0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [W-1:0]   s_out, act_out, sp_out;
  logic           sat_out;

  int tests_run = 0;
  int tests_failed = 0;
  logic [49:0] got, exp;

  ff_mac_accumulator #(.width(16), .int_bits(5), .frac_bits(10), .lanes(4), .fi(8), .leak_shift(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a_package(a_package), .w_package(w_package), .b(b), .act_mode(act_mode),
    .out_valid(out_valid), .out_ready(out_ready), .s_out(s_out), .act_out(act_out),
    .sp_out(sp_out), .sat_out(sat_out)
  );

  always #5 clk = ~clk;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task set_beat(input logic [15:0] a, input logic [15:0] w, input logic [15:0] bb, input logic [1:0] m);
    in_valid  = 1'b1;
    a_package = {L{a}};
    w_package = {L{w}};
    b         = bb;
    act_mode  = m;
  endtask

  // Two back-to-back beats with identical data; returns #1 after the second is accepted.
  task run_neuron(input logic [15:0] a, input logic [15:0] w, input logic [15:0] bb, input logic [1:0] m);
    set_beat(a, w, bb, m);
    tick;
    set_beat(a, w, bb, m);
    tick;
    in_valid = 1'b0;
  endtask

  task test_reset;
    tick;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    got = {out_valid, s_out, act_out, sp_out, sat_out};
    tests_run++;
    if (got !== 50'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected 0", got);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
  endtask

  task test_basic_relu;
    run_neuron(16'h0400, 16'h0200, 16'h0100, 2'd1);
    got = {out_valid, s_out, act_out, sp_out, sat_out};
    exp = {1'b1, 16'h1100, 16'h1100, 16'h0400, 1'b0};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL basic_relu: got %h expected %h", got, exp);
    end
    tick;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_consume: out_valid got %b expected 0", out_valid);
    end
  endtask

  task test_neg_relu;
    set_beat(16'h0400, 16'hFE00, 16'h0000, 2'd1);
    tick;
    set_beat(16'h0400, 16'hFE00, 16'h7FFF, 2'd2);
    tick;
    in_valid = 1'b0;
    got = {out_valid, s_out, act_out, sp_out, sat_out};
    exp = {1'b1, 16'hF000, 16'h0000, 16'h0000, 1'b0};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL neg_relu: got %h expected %h", got, exp);
    end
    tick;
  endtask

  task test_modes;
    run_neuron(16'h0400, 16'hFE00, 16'h0000, 2'd2);
    got = {out_valid, s_out, act_out, sp_out, sat_out};
    exp = {1'b1, 16'hF000, 16'hFE00, 16'h0080, 1'b0};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL neg_leaky: got %h expected %h", got, exp);
    end
    tick;
    run_neuron(16'h0400, 16'hFE00, 16'h0000, 2'd3);
    got = {out_valid, s_out, act_out, sp_out, sat_out};
    exp = {1'b1, 16'hF000, 16'hF000, 16'h0400, 1'b0};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL neg_identity3: got %h expected %h", got, exp);
    end
    tick;
    run_neuron(16'h0001, 16'hFFFF, 16'h0000, 2'd0);
    got = {out_valid, s_out, act_out, sp_out, sat_out};
    exp = {1'b1, 16'hFFF8, 16'hFFF8, 16'h0400, 1'b0};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL floor_identity: got %h expected %h", got, exp);
    end
    tick;
    run_neuron(16'h0001, 16'hFFFF, 16'h0000, 2'd2);
    got = {out_valid, s_out, act_out, sp_out, sat_out};
    exp = {1'b1, 16'hFFF8, 16'hFFFF, 16'h0080, 1'b0};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL floor_leaky: got %h expected %h", got, exp);
    end
    tick;
  endtask

  task test_saturation;
    run_neuron(16'h3C00, 16'h3C00, 16'h0000, 2'd1);
    got = {out_valid, s_out, act_out, sp_out, sat_out};
    exp = {1'b1, 16'h7FFF, 16'h7FFF, 16'h0400, 1'b1};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL sat_pos: got %h expected %h", got, exp);
    end
    tick;
    run_neuron(16'h3C00, 16'hC400, 16'h0000, 2'd1);
    got = {out_valid, s_out, act_out, sp_out, sat_out};
    exp = {1'b1, 16'h8000, 16'h0000, 16'h0000, 1'b1};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL sat_neg: got %h expected %h", got, exp);
    end
    tick;
  endtask

  task test_backpressure;
    out_ready = 1'b0;
    run_neuron(16'h0400, 16'h0200, 16'h0100, 2'd1);
    exp = {1'b1, 16'h1100, 16'h1100, 16'h0400, 1'b0};
    for (int i = 0; i < 5; i++) begin
      got = {out_valid, s_out, act_out, sp_out, sat_out};
      tests_run++;
      if (got !== exp || in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_cycle%0d: got %h ready %b expected %h ready 0", i, got, in_ready, exp);
      end
      tick;
    end
    set_beat(16'h0400, 16'hFE00, 16'h0000, 2'd1);
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL release_ready: got %b expected 1", in_ready);
    end
    tick;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL handover_valid: got %b expected 0", out_valid);
    end
    set_beat(16'h0400, 16'hFE00, 16'h0000, 2'd1);
    tick;
    in_valid = 1'b0;
    got = {out_valid, s_out, act_out, sp_out, sat_out};
    exp = {1'b1, 16'hF000, 16'h0000, 16'h0000, 1'b0};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL handover_result: got %h expected %h", got, exp);
    end
    tick;
  endtask

  task test_bubbles;
    set_beat(16'h0400, 16'h0200, 16'h0100, 2'd1);
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    tick;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bubble_early_valid: got %b expected 0", out_valid);
    end
    set_beat(16'h0400, 16'h0200, 16'h0000, 2'd0);
    tick;
    in_valid = 1'b0;
    got = {out_valid, s_out, act_out, sp_out, sat_out};
    exp = {1'b1, 16'h1100, 16'h1100, 16'h0400, 1'b0};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL bubble_result: got %h expected %h", got, exp);
    end
    tick;
  endtask

  task test_reset_mid;
    set_beat(16'h0400, 16'h0200, 16'h0100, 2'd1);
    tick;
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_hold: ready %b valid %b expected 0 0", in_ready, out_valid);
    end
    tick;
    reset = 1'b0;
    #1;
    set_beat(16'h0400, 16'hFE00, 16'h0000, 2'd2);
    tick;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_cnt: out_valid got %b expected 0", out_valid);
    end
    set_beat(16'h0400, 16'hFE00, 16'h0000, 2'd2);
    tick;
    in_valid = 1'b0;
    got = {out_valid, s_out, act_out, sp_out, sat_out};
    exp = {1'b1, 16'hF000, 16'hFE00, 16'h0080, 1'b0};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL midreset_fresh: got %h expected %h", got, exp);
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_basic_relu;
    test_neg_relu;
    test_modes;
    test_saturation;
    test_backpressure;
    test_bubbles;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ff_mac_accumulator.md
Name: ff_mac_accumulator

Overview:
- Multi-cycle feedforward neuron engine. Computes one neuron's pre-activation s = b + sum of a*w over fan-in fi, taking `lanes` a/w pairs per beat.
- Saturates s to width bits, then applies a selectable piecewise-linear activation and its derivative.
- Successor to the single-cycle fi-wide tree-adder neuron: fan-in is decoupled from datapath width, accumulation is full-precision, and flow control is valid/ready.
- Sits between weight/activation memories and the next layer's activation and sp (activation-prime) storage.

Parameters:
- width, 16, bits per fixed-point word (two's complement)
- int_bits, 5, integer bits excluding sign
- frac_bits, 10, fractional bits (width = 1 + int_bits + frac_bits)
- lanes, 4, a/w pairs accepted per beat; power of 2
- fi, 16, fan-in per neuron; must be a multiple of lanes
- leak_shift, 3, right shift applied to negative s in leaky mode

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  beat valid
- in_ready  output  1  beat accepted when in_valid && in_ready
- a_package  input  width*lanes  activations, lane k at bits [width*(k+1)-1 : width*k], signed
- w_package  input  width*lanes  weights, same packing, signed
- b  input  width  bias, signed; sampled on the first beat only
- act_mode  input  2  activation mode; sampled on the first beat only: 0 identity, 1 relu, 2 leaky relu, 3 identity
- out_valid  output  1  result valid
- out_ready  input  1  result consumed when out_valid && out_ready
- s_out  output  width  saturated pre-activation
- act_out  output  width  activation
- sp_out  output  width  activation derivative
- sat_out  output  1  s was clipped for this result

Behaviour:
- Beats per neuron: NB = fi/lanes. Beat counter: $clog2(NB) bits, minimum 1 bit.
- Product per lane: full 2*width signed product, arithmetically shifted right by frac_bits (truncate toward minus infinity).
- Lane sum and accumulator: ACCW = 2*width - frac_bits + $clog2(fi) + 1 bits, sign-extended. No intermediate wrap or saturation.
- States:
  - IDLE: beat counter 0, waiting for the first beat.
  - ACCUM: beats 1..NB-1 of the current neuron.
  - OUT: result held.
- First beat, accepted in IDLE (or in OUT on the same cycle the result is consumed):
  - acc <= sext(b) + lane_sum; mode_r <= act_mode; cnt <= 1.
  - Next state is ACCUM, or OUT if NB = 1.
- Later beats: acc <= acc + lane_sum; cnt increments.
- Last beat (cnt = NB-1, or the first beat when NB = 1):
  - Final sum F = acc_or_bias + lane_sum.
  - Register s_out <= sat(F) and sat_out <= clipped.
  - Register act_out and sp_out from sat(F) and mode_r (act_mode when NB = 1).
  - out_valid <= 1; state OUT; cnt <= 0.
  - Latency: out_valid rises the cycle after the last beat is accepted.
- Saturation: F > 2^(width-1)-1 gives 0x7FFF-style maximum; F < -2^(width-1) gives 0x8000-style minimum. sat_out = 1 in either case.
- Activation, with ONE = 2^frac_bits:
  - identity: act = s, sp = ONE.
  - relu: s > 0 gives act = s, sp = ONE; otherwise act = 0, sp = 0.
  - leaky: s >= 0 gives act = s, sp = ONE; otherwise act = s >>> leak_shift, sp = ONE >> leak_shift.
- Handshake:
  - in_ready = !reset && (state != OUT || out_ready).
  - Gaps in in_valid between beats are allowed; acc and cnt hold.
  - OUT with out_ready = 1 and no first beat: out_valid clears next cycle, state IDLE.
  - OUT with out_ready = 1 and a first beat presented: result is consumed and the new beat is accepted in the same cycle (no bubble). If NB = 1, out_valid stays 1 with the new result.
  - OUT with out_ready = 0: s_out, act_out, sp_out, sat_out stay stable; in_ready = 0.
- b and act_mode are ignored on non-first beats.
- Reset, at any time including mid-neuron: state IDLE, cnt 0, acc 0, out_valid 0, s_out/act_out/sp_out 0, sat_out 0, in_ready 0 while reset is asserted. A partial neuron is discarded.

Test Plan:
- Common setup: width 16, frac_bits 10, lanes 4, fi 8 (NB = 2).
- Basic relu: all a = 0x0400, all w = 0x0200, b = 0x0100, mode 1, two back-to-back beats -> one cycle after beat 2: out_valid = 1, s_out = act_out = 0x1100, sp_out = 0x0400, sat_out = 0.
- Negative input, relu: w = 0xFE00, b = 0 -> s_out = 0xF000, act_out = 0, sp_out = 0.
- Negative input, leaky (mode 2): w = 0xFE00, b = 0 -> s_out = 0xF000, act_out = 0xFE00, sp_out = 0x0080.
- Saturation: a = w = 0x3C00 -> s_out = 0x7FFF, sat_out = 1. With w = 0xC400 -> s_out = 0x8000, sat_out = 1.
- Backpressure: hold out_ready = 0 for 5 cycles -> outputs stable and in_ready = 0 throughout. Then raise out_ready with the next first beat presented -> beat accepted that cycle, out_valid drops next cycle, new result appears one cycle after its beat 2.
- Bubbles and reset: 3 idle cycles between beat 1 and beat 2 -> result identical to the basic relu case. Pulse reset after beat 1 -> out_valid stays 0. A fresh 2-beat neuron afterwards -> correct result with no residue from the discarded neuron.
